// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// MEM/WB pipeline register and regfile write-port driver for the LC-3b
// pipeline. It latches the retiring instruction, selects the writeback value
// and drives the regfile load/dest/data once per instruction. It also owns
// the architectural NZP register and a retired-instruction counter.
//
// Ports
//   clk, reset        clock (rising edge); asynchronous active-high reset
//   stall, flush      hold / invalidate the MEM/WB register (flush wins)
//   in_*              instruction fields and datapath values from MEM
//   regfile_load      regfile write enable, one cycle per instruction
//   regfile_dest      regfile write address (R7 for JSR/TRAP links)
//   regfile_data      regfile write data; also the forwarding source
//   wb_valid          MEM/WB register holds a valid instruction
//   cc_nzp            architectural {N,Z,P}
//   retired_count     instructions retired since reset (wraps)
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int         CNT_WIDTH = 32,
  parameter logic [2:0] CC_RESET  = 3'b010
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [15:0]          in_ir,
  input  logic [15:0]          in_mem_rdata,
  input  logic                 in_addr0,
  input  logic [15:0]          in_pc,
  input  logic [15:0]          in_br_adder_out,
  input  logic [15:0]          in_alu_out,
  input  logic                 in_load_regfile,
  input  logic [2:0]           in_regfile_sel,
  input  logic                 in_dest_r7,
  input  logic                 in_load_cc,
  output logic                 regfile_load,
  output logic [2:0]           regfile_dest,
  output logic [15:0]          regfile_data,
  output logic                 wb_valid,
  output logic [2:0]           cc_nzp,
  output logic [CNT_WIDTH-1:0] retired_count
);

  // Writeback source encodings.
  localparam logic [2:0] SEL_MEM = 3'd0;
  localparam logic [2:0] SEL_PC  = 3'd1;
  localparam logic [2:0] SEL_BR  = 3'd2;
  localparam logic [2:0] SEL_ALU = 3'd3;
  localparam logic [2:0] SEL_LDB = 3'd4;

  // MEM/WB register.
  logic        r_valid;
  logic        r_fresh;
  logic [15:0] r_ir;
  logic [15:0] r_mem_rdata;
  logic        r_addr0;
  logic [15:0] r_pc;
  logic [15:0] r_br_adder_out;
  logic [15:0] r_alu_out;
  logic        r_load_regfile;
  logic [2:0]  r_regfile_sel;
  logic        r_dest_r7;
  logic        r_load_cc;

  // Architectural state.
  logic [2:0]           r_cc;
  logic [CNT_WIDTH-1:0] r_count;

  logic        w_fire;
  logic [15:0] w_data;
  logic [2:0]  w_nzp;

  // Side effects only in the first cycle an instruction sits here, so a
  // stalled instruction writes and counts exactly once.
  assign w_fire = r_valid & r_fresh;

  always_comb begin
    // NOTE: default assignment first so no path leaves w_data unassigned,
    // which would otherwise infer a latch.
    w_data = 16'h0000;
    case (r_regfile_sel)
      SEL_MEM: w_data = r_mem_rdata;
      SEL_PC:  w_data = r_pc;
      SEL_BR:  w_data = r_br_adder_out;
      SEL_ALU: w_data = r_alu_out;
      SEL_LDB: w_data = {8'h00, r_addr0 ? r_mem_rdata[15:8] : r_mem_rdata[7:0]};
      default: w_data = 16'h0000;
    endcase
  end

  // NZP from the writeback value, even when no register is written.
  assign w_nzp[2] = w_data[15];
  assign w_nzp[1] = (w_data == 16'h0000);
  assign w_nzp[0] = ~w_nzp[2] & ~w_nzp[1];

  // Pipeline register: flush > stall > load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_fresh        <= 1'b0;
      r_ir           <= 16'h0000;
      r_mem_rdata    <= 16'h0000;
      r_addr0        <= 1'b0;
      r_pc           <= 16'h0000;
      r_br_adder_out <= 16'h0000;
      r_alu_out      <= 16'h0000;
      r_load_regfile <= 1'b0;
      r_regfile_sel  <= 3'd0;
      r_dest_r7      <= 1'b0;
      r_load_cc      <= 1'b0;
    end else if (flush) begin
      // NOTE: non-blocking assignments for all clocked state so every
      // register samples its pre-edge inputs regardless of statement order.
      r_valid <= 1'b0;
      r_fresh <= 1'b0;
    end else if (stall) begin
      r_fresh <= 1'b0;
    end else begin
      r_valid        <= in_valid;
      r_fresh        <= in_valid;
      r_ir           <= in_ir;
      r_mem_rdata    <= in_mem_rdata;
      r_addr0        <= in_addr0;
      r_pc           <= in_pc;
      r_br_adder_out <= in_br_adder_out;
      r_alu_out      <= in_alu_out;
      r_load_regfile <= in_load_regfile;
      r_regfile_sel  <= in_regfile_sel;
      r_dest_r7      <= in_dest_r7;
      r_load_cc      <= in_load_cc;
    end
  end

  // Condition codes and retire counter update on the edge that ends the
  // instruction's first cycle here, independent of stall/flush at that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cc    <= CC_RESET;
      r_count <= '0;
    end else if (w_fire) begin
      if (r_load_cc) r_cc <= w_nzp;
      r_count <= r_count + 1'b1;
    end
  end

  assign regfile_load  = w_fire & r_load_regfile;
  assign regfile_dest  = r_dest_r7 ? 3'b111 : r_ir[11:9];
  assign regfile_data  = w_data;
  assign wb_valid      = r_valid;
  assign cc_nzp        = r_cc;
  assign retired_count = r_count;

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed bench for writeback_stage: a table of single-instruction vectors
// with hand-computed results, followed by hand-written sequences for stall,
// flush+stall, asynchronous reset and retire-counter wrap.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_ir;
  logic [15:0] in_mem_rdata;
  logic        in_addr0;
  logic [15:0] in_pc;
  logic [15:0] in_br_adder_out;
  logic [15:0] in_alu_out;
  logic        in_load_regfile;
  logic [2:0]  in_regfile_sel;
  logic        in_dest_r7;
  logic        in_load_cc;
  logic        regfile_load;
  logic [2:0]  regfile_dest;
  logic [15:0] regfile_data;
  logic        wb_valid;
  logic [2:0]  cc_nzp;
  logic [31:0] retired_count;

  writeback_stage #(.CNT_WIDTH(32), .CC_RESET(3'b010)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ir           (in_ir),
    .in_mem_rdata    (in_mem_rdata),
    .in_addr0        (in_addr0),
    .in_pc           (in_pc),
    .in_br_adder_out (in_br_adder_out),
    .in_alu_out      (in_alu_out),
    .in_load_regfile (in_load_regfile),
    .in_regfile_sel  (in_regfile_sel),
    .in_dest_r7      (in_dest_r7),
    .in_load_cc      (in_load_cc),
    .regfile_load    (regfile_load),
    .regfile_dest    (regfile_dest),
    .regfile_data    (regfile_data),
    .wb_valid        (wb_valid),
    .cc_nzp          (cc_nzp),
    .retired_count   (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] mem;
    logic        addr0;
    logic [15:0] pc;
    logic [15:0] br;
    logic [15:0] alu;
    logic        lr;
    logic [2:0]  sel;
    logic        r7;
    logic        lcc;
    logic        exp_load;
    logic [2:0]  exp_dest;
    logic [15:0] exp_data;
    logic [2:0]  exp_cc;
  } vec_t;

  vec_t vecs[8];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_ir           = v.ir;
    in_mem_rdata    = v.mem;
    in_addr0        = v.addr0;
    in_pc           = v.pc;
    in_br_adder_out = v.br;
    in_alu_out      = v.alu;
    in_load_regfile = v.lr;
    in_regfile_sel  = v.sel;
    in_dest_r7      = v.r7;
    in_load_cc      = v.lcc;
    in_valid        = 1'b1;
  endtask

  initial begin
    //            ir       mem      a0 pc       br       alu      lr sel r7 lcc  load dest data     cc
    vecs[0] = '{16'h16C2, 16'h5555, 0, 16'h3000, 16'h1111, 16'h8001, 1, 3, 0, 1,   1, 3, 16'h8001, 3'b100}; // ADD R3
    vecs[1] = '{16'h2240, 16'hAB00, 1, 16'h3000, 16'h1111, 16'h2222, 1, 4, 0, 1,   1, 1, 16'h00AB, 3'b001}; // LDB hi byte
    vecs[2] = '{16'h2240, 16'hAB00, 0, 16'h3000, 16'h1111, 16'h2222, 1, 4, 0, 1,   1, 1, 16'h0000, 3'b010}; // LDB lo byte
    vecs[3] = '{16'hEA00, 16'h5555, 0, 16'h3000, 16'h1234, 16'h8000, 1, 2, 0, 0,   1, 5, 16'h1234, 3'b010}; // LEA, no cc
    vecs[4] = '{16'h2800, 16'h7FFF, 0, 16'h3000, 16'h1111, 16'h8000, 0, 0, 0, 1,   0, 4, 16'h7FFF, 3'b001}; // cc only
    vecs[5] = '{16'h2800, 16'hFFFF, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 5, 0, 1,   1, 4, 16'h0000, 3'b010}; // sel 5
    vecs[6] = '{16'h16C2, 16'h5555, 0, 16'h8000, 16'h1111, 16'h2222, 1, 1, 1, 1,   1, 7, 16'h8000, 3'b100}; // link R7
    vecs[7] = '{16'h16C2, 16'hFFFF, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 7, 0, 1,   1, 3, 16'h0000, 3'b010}; // sel 7

    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_ir = '0; in_mem_rdata = '0; in_addr0 = 1'b0; in_pc = '0; in_br_adder_out = '0;
    in_alu_out = '0; in_load_regfile = 1'b0; in_regfile_sel = '0; in_dest_r7 = 1'b0; in_load_cc = 1'b0;
    #12 reset = 1'b0;
    tick();

    check("reset load",  {31'd0, regfile_load}, 32'd0);
    check("reset dest",  {29'd0, regfile_dest}, 32'd0);
    check("reset data",  {16'd0, regfile_data}, 32'd0);
    check("reset valid", {31'd0, wb_valid},     32'd0);
    check("reset cc",    {29'd0, cc_nzp},       32'd2);
    check("reset count", retired_count,         32'd0);

    // Table: one instruction followed by a bubble.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      tick();
      check($sformatf("v%0d load", i),  {31'd0, regfile_load}, {31'd0, vecs[i].exp_load});
      check($sformatf("v%0d dest", i),  {29'd0, regfile_dest}, {29'd0, vecs[i].exp_dest});
      check($sformatf("v%0d data", i),  {16'd0, regfile_data}, {16'd0, vecs[i].exp_data});
      check($sformatf("v%0d valid", i), {31'd0, wb_valid},     32'd1);
      in_valid = 1'b0;
      exp_count++;
      tick();
      check($sformatf("v%0d cc", i),    {29'd0, cc_nzp},       {29'd0, vecs[i].exp_cc});
      check($sformatf("v%0d count", i), retired_count,         exp_count);
      check($sformatf("v%0d bubble load", i), {31'd0, regfile_load}, 32'd0);
    end

    // JSR into R7, then stalled three cycles: one write, one retire.
    drive('{16'h4800, 16'h0000, 0, 16'h3002, 16'h0000, 16'h0000, 1, 1, 1, 0,
            0, 0, 16'h0000, 3'b000});
    tick();
    stall = 1'b1;
    in_pc = 16'h9999;  // must be ignored while stalled
    check("jsr load", {31'd0, regfile_load}, 32'd1);
    check("jsr dest", {29'd0, regfile_dest}, 32'd7);
    check("jsr data", {16'd0, regfile_data}, 32'h3002);
    exp_count++;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d load", c),  {31'd0, regfile_load}, 32'd0);
      check($sformatf("stall%0d valid", c), {31'd0, wb_valid},     32'd1);
      check($sformatf("stall%0d data", c),  {16'd0, regfile_data}, 32'h3002);
      check($sformatf("stall%0d count", c), retired_count,         exp_count);
    end
    stall = 1'b0;
    in_valid = 1'b0;
    tick();
    check("post stall valid", {31'd0, wb_valid}, 32'd0);
    check("post stall count", retired_count,     exp_count);
    check("jsr cc kept",      {29'd0, cc_nzp},   32'd2);

    // flush and stall together on a valid ADD: flush wins.
    drive(vecs[0]);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    check("flush valid", {31'd0, wb_valid},     32'd0);
    check("flush load",  {31'd0, regfile_load}, 32'd0);
    tick();
    check("flush count", retired_count,   exp_count);
    check("flush cc",    {29'd0, cc_nzp}, 32'd2);

    // Two back-to-back ADDs; reset mid-cycle while the second is writing.
    drive(vecs[0]);
    tick();
    tick();
    exp_count++;
    check("pre-reset load",  {31'd0, regfile_load}, 32'd1);
    check("pre-reset cc",    {29'd0, cc_nzp},       32'd4);
    check("pre-reset count", retired_count,         exp_count);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async reset load",  {31'd0, regfile_load}, 32'd0);
    check("async reset valid", {31'd0, wb_valid},     32'd0);
    check("async reset cc",    {29'd0, cc_nzp},       32'd2);
    check("async reset count", retired_count,         32'd0);
    #1 reset = 1'b0;
    tick();
    tick();
    check("after reset count", retired_count, 32'd0);
    check("after reset load",  {31'd0, regfile_load}, 32'd0);

    // Retire counter wraps from all-ones.
    force dut.r_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_count;
    check("preload count", retired_count, 32'hFFFF_FFFF);
    drive(vecs[3]);
    tick();
    in_valid = 1'b0;
    tick();
    check("wrap count", retired_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
